// File: rtl/ball_motion_ctrl_pkg.sv
// Shared constants, FSM state type and per-axis step/reflect helper for the ball display path.
package ball_pkg;

  localparam int unsigned H_RES     = 640;
  localparam int unsigned V_RES     = 480;
  localparam int unsigned BALL_SIZE = 16;

  localparam logic [2:0] BALL_RGB  = 3'b100;
  localparam logic [2:0] BG_RGB    = 3'b001;
  localparam logic [2:0] BLANK_RGB = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    CALC_X,
    CALC_Y,
    COMMIT
  } ball_state_t;

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
    logic       hit;
  } axis_step_t;

  // One axis update in 11-bit signed: move by step, clamp to [1, max_pos] and reflect.
  function automatic axis_step_t axis_step(input logic [9:0] pos, input logic dir,
                                           input logic [9:0] step, input logic [9:0] max_pos);
    logic signed [10:0] n;
    axis_step_t r;
    n = dir ? ($signed({1'b0, pos}) + $signed({1'b0, step}))
            : ($signed({1'b0, pos}) - $signed({1'b0, step}));
    r.pos = n[9:0];
    r.dir = dir;
    r.hit = 1'b0;
    if (n >= $signed({1'b0, max_pos})) begin
      r.pos = max_pos;
      r.dir = 1'b0;
      r.hit = 1'b1;
    end else if (n <= 11'sd1) begin
      r.pos = 10'd1;
      r.dir = 1'b1;
      r.hit = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ball_motion_ctrl_if.sv
// Raster inputs, motion controls and ball/colour outputs of the ball motion controller.
interface ball_motion_ctrl_if;
  logic       v_sync;
  logic [8:0] line;
  logic [9:0] pixel;
  logic       run;
  logic [1:0] speed_sel;
  logic [9:0] ball_x;
  logic [8:0] ball_y;
  logic       dir_x;
  logic       dir_y;
  logic       bounce;
  logic [7:0] bounce_cnt;
  logic       ball_on;
  logic [2:0] rgb;

  modport master (
    output v_sync, line, pixel, run, speed_sel,
    input  ball_x, ball_y, dir_x, dir_y, bounce, bounce_cnt, ball_on, rgb
  );

  modport slave (
    input  v_sync, line, pixel, run, speed_sel,
    output ball_x, ball_y, dir_x, dir_y, bounce, bounce_cnt, ball_on, rgb
  );
endinterface

// File: rtl/ball_motion_ctrl_sync_fall_det.sv
// Two-flop synchroniser followed by a registered falling-edge pulse (3 clk from input fall).
module sync_fall_det (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic fall
);

  // sh[0], sh[1] synchronise; sh[2] holds the previous synchronised value. Idle level is high.
  logic [2:0] sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh   <= '1;
      fall <= 1'b0;
    end else begin
      sh   <= {sh[1:0], sig};
      fall <= sh[2] & ~sh[1];
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Frame-synchronous bouncing-ball controller: steps the ball during vertical blanking and
// produces the per-pixel ball/background colour.
module ball_motion_ctrl #(
  parameter int unsigned H_RES     = ball_pkg::H_RES,
  parameter int unsigned V_RES     = ball_pkg::V_RES,
  parameter int unsigned BALL_SIZE = ball_pkg::BALL_SIZE,
  parameter int unsigned STEP_X    = 2,
  parameter int unsigned STEP_Y    = 1,
  parameter int unsigned INIT_X    = 312,
  parameter int unsigned INIT_Y    = 232,
  parameter int unsigned FRAME_DIV = 1,
  parameter logic [2:0]  BALL_RGB  = ball_pkg::BALL_RGB,
  parameter logic [2:0]  BG_RGB    = ball_pkg::BG_RGB
) (
  input logic               clk,
  input logic               reset,
  ball_motion_ctrl_if.slave bus
);
  import ball_pkg::*;

  localparam logic [9:0]  XMAX     = 10'(H_RES - BALL_SIZE + 1);
  localparam logic [9:0]  YMAX     = 10'(V_RES - BALL_SIZE + 1);
  localparam logic [15:0] DIV_LAST = 16'(FRAME_DIV - 1);

  ball_state_t state, nstate;
  logic        frame_tick;
  logic [15:0] div_q;
  logic [1:0]  spd_q;
  axis_step_t  nx_q;
  axis_step_t  ay;
  logic [9:0]  step_x, step_y;

  logic [9:0]  ball_x_q;
  logic [9:0]  ball_y_q;
  logic        dir_x_q, dir_y_q, bounce_q, ball_on_q;
  logic [7:0]  bounce_cnt_q;
  logic [2:0]  rgb_q;

  logic div_last, div_clr, div_inc, latch_spd, calc_x_en, load_en;
  logic active, in_x, in_y, on_d;

  sync_fall_det u_vs_fall (
    .clk   (clk),
    .reset (reset),
    .sig   (bus.v_sync),
    .fall  (frame_tick)
  );

  assign div_last = (div_q == DIV_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:       if (bus.run) nstate = WAIT_FRAME;
      WAIT_FRAME: begin
        if (!bus.run)                   nstate = IDLE;
        else if (frame_tick && div_last) nstate = CALC_X;
      end
      CALC_X:     nstate = CALC_Y;
      CALC_Y:     nstate = COMMIT;
      COMMIT:     nstate = WAIT_FRAME;
      default:    nstate = IDLE;
    endcase
  end

  always_comb begin
    div_clr   = 1'b0;
    div_inc   = 1'b0;
    latch_spd = 1'b0;
    calc_x_en = 1'b0;
    load_en   = 1'b0;
    unique case (state)
      IDLE:       div_clr = bus.run;
      WAIT_FRAME: begin
        if (bus.run && frame_tick) begin
          if (div_last) begin
            div_clr   = 1'b1;
            latch_spd = 1'b1;
          end else begin
            div_inc = 1'b1;
          end
        end
      end
      CALC_X:     calc_x_en = 1'b1;
      CALC_Y:     load_en   = 1'b1;
      default:    ;
    endcase
  end

  assign step_x = 10'(STEP_X * (int'(spd_q) + 1));
  assign step_y = 10'(STEP_Y * (int'(spd_q) + 1));
  assign ay     = axis_step(ball_y_q, dir_y_q, step_y, YMAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      spd_q <= '0;
      nx_q  <= '0;
    end else begin
      if (div_clr)        div_q <= '0;
      else if (div_inc)   div_q <= div_q + 16'd1;
      if (latch_spd)      spd_q <= bus.speed_sel;
      if (calc_x_en)      nx_q  <= axis_step(ball_x_q, dir_x_q, step_x, XMAX);
    end
  end

  // Visible registers load on the edge that enters COMMIT, so the new position, directions and
  // the single bounce pulse are all present for exactly the COMMIT cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_x_q     <= 10'(INIT_X);
      ball_y_q     <= 10'(INIT_Y);
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      bounce_q     <= 1'b0;
      bounce_cnt_q <= '0;
    end else begin
      bounce_q <= 1'b0;
      if (load_en) begin
        ball_x_q <= nx_q.pos;
        dir_x_q  <= nx_q.dir;
        ball_y_q <= ay.pos;
        dir_y_q  <= ay.dir;
        if (nx_q.hit || ay.hit) begin
          bounce_q <= 1'b1;
          if (bounce_cnt_q != 8'hFF) bounce_cnt_q <= bounce_cnt_q + 8'd1;
        end
      end
    end
  end

  assign active = (bus.line != '0) && (bus.pixel != '0);
  assign in_x   = (bus.pixel >= ball_x_q) &&
                  ({1'b0, bus.pixel} < ({1'b0, ball_x_q} + 11'(BALL_SIZE)));
  assign in_y   = ({1'b0, bus.line} >= ball_y_q) &&
                  ({2'b00, bus.line} < ({1'b0, ball_y_q} + 11'(BALL_SIZE)));
  assign on_d   = active && in_x && in_y;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_on_q <= 1'b0;
      rgb_q     <= BLANK_RGB;
    end else begin
      ball_on_q <= on_d;
      rgb_q     <= on_d ? BALL_RGB : (active ? BG_RGB : BLANK_RGB);
    end
  end

  assign bus.ball_x     = ball_x_q;
  assign bus.ball_y     = ball_y_q[8:0];
  assign bus.dir_x      = dir_x_q;
  assign bus.dir_y      = dir_y_q;
  assign bus.bounce     = bounce_q;
  assign bus.bounce_cnt = bounce_cnt_q;
  assign bus.ball_on    = ball_on_q;
  assign bus.rgb        = rgb_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: five differently parameterised instances share one stimulus and are
// checked every cycle against a frame-level model, plus hand-computed literal expectations.
module tb_ball_motion_ctrl;

  localparam int NI = 5;
  localparam int P_H  [NI] = '{640, 640, 640, 640, 20};
  localparam int P_V  [NI] = '{480, 480, 480, 480, 20};
  localparam int P_BS [NI] = '{16, 16, 16, 16, 16};
  localparam int P_SX [NI] = '{2, 2, 4, 2, 2};
  localparam int P_SY [NI] = '{1, 1, 1, 1, 1};
  localparam int P_IX [NI] = '{312, 312, 620, 623, 3};
  localparam int P_IY [NI] = '{232, 232, 232, 464, 3};
  localparam int P_FD [NI] = '{1, 2, 1, 1, 1};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       v_sync = 1'b1;
  logic       run = 1'b0;
  logic [8:0] line = '0;
  logic [9:0] pixel = '0;
  logic [1:0] speed_sel = '0;

  always #5 clk = ~clk;

  logic [9:0] o_x   [NI];
  logic [8:0] o_y   [NI];
  logic       o_dx  [NI];
  logic       o_dy  [NI];
  logic       o_b   [NI];
  logic [7:0] o_cnt [NI];
  logic       o_on  [NI];
  logic [2:0] o_rgb [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ball_motion_ctrl_if u_if ();
    assign u_if.v_sync    = v_sync;
    assign u_if.line      = line;
    assign u_if.pixel     = pixel;
    assign u_if.run       = run;
    assign u_if.speed_sel = speed_sel;
    assign o_x[g]   = u_if.ball_x;
    assign o_y[g]   = u_if.ball_y;
    assign o_dx[g]  = u_if.dir_x;
    assign o_dy[g]  = u_if.dir_y;
    assign o_b[g]   = u_if.bounce;
    assign o_cnt[g] = u_if.bounce_cnt;
    assign o_on[g]  = u_if.ball_on;
    assign o_rgb[g] = u_if.rgb;

    ball_motion_ctrl #(
      .H_RES     (P_H[g]),
      .V_RES     (P_V[g]),
      .BALL_SIZE (P_BS[g]),
      .STEP_X    (P_SX[g]),
      .STEP_Y    (P_SY[g]),
      .INIT_X    (P_IX[g]),
      .INIT_Y    (P_IY[g]),
      .FRAME_DIV (P_FD[g])
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0d expected %0d", nm, inst, act, exp);
    end
  endtask

  // Frame-level model: current position, pending update and its remaining visibility delay.
  int mx [NI], my [NI], mdx [NI], mdy [NI], mhits [NI], div [NI];
  int px [NI], py [NI], pdx [NI], pdy [NI], phit [NI], cd [NI];
  int pulses [NI];
  bit exp_on [NI];
  int exp_rgb [NI];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      mx[i] = P_IX[i]; my[i] = P_IY[i]; mdx[i] = 1; mdy[i] = 1;
      mhits[i] = 0; div[i] = 0; cd[i] = 0; phit[i] = 0; pulses[i] = 0;
    end
  endtask

  task automatic axis(input int p, input int d, input int st, input int lim,
                      output int np, output int nd, output int h);
    np = d ? p + st : p - st;
    nd = d;
    h  = 0;
    if (np >= lim) begin np = lim; nd = 0; h = 1; end
    else if (np <= 1) begin np = 1; nd = 1; h = 1; end
  endtask

  task automatic model_fall();
    int hx, hy;
    for (int i = 0; i < NI; i++) begin
      if (!run) begin div[i] = 0; continue; end
      div[i]++;
      if (div[i] < P_FD[i]) continue;
      div[i] = 0;
      axis(mx[i], mdx[i], P_SX[i] * (int'(speed_sel) + 1), P_H[i] - P_BS[i] + 1, px[i], pdx[i], hx);
      axis(my[i], mdy[i], P_SY[i] * (int'(speed_sel) + 1), P_V[i] - P_BS[i] + 1, py[i], pdy[i], hy);
      phit[i] = (hx | hy);
      cd[i] = 7;
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      bit act_v, inside_v;
      act_v    = (line != 0) && (pixel != 0);
      inside_v = (pixel >= mx[i]) && (pixel < mx[i] + P_BS[i]) &&
                 (line >= my[i]) && (line < my[i] + P_BS[i]);
      exp_on[i]  = !reset && act_v && inside_v;
      exp_rgb[i] = reset ? 0 : (exp_on[i] ? 4 : (act_v ? 1 : 0));
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      bit app;
      app = 1'b0;
      if (cd[i] > 0) begin
        cd[i]--;
        if (cd[i] == 0) begin
          mx[i] = px[i]; my[i] = py[i]; mdx[i] = pdx[i]; mdy[i] = pdy[i];
          if (phit[i] != 0) mhits[i]++;
          app = 1'b1;
        end
      end
      if (o_b[i] === 1'b1) pulses[i]++;
      chk("ball_x", i, o_x[i], mx[i]);
      chk("ball_y", i, o_y[i], my[i]);
      chk("dir_x", i, o_dx[i], mdx[i]);
      chk("dir_y", i, o_dy[i], mdy[i]);
      chk("bounce", i, o_b[i], (app && phit[i] != 0) ? 1 : 0);
      chk("bounce_cnt", i, o_cnt[i], (mhits[i] > 255) ? 255 : mhits[i]);
      chk("ball_on", i, o_on[i], (reset || !exp_on[i]) ? 0 : 1);
      chk("rgb", i, o_rgb[i], reset ? 0 : exp_rgb[i]);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic frame();
    v_sync = 1'b0;
    model_fall();
    tick(2);
    v_sync = 1'b1;
    tick(12);
  endtask

  task automatic set_run(input logic r);
    if (run != r) begin
      run = r;
      for (int i = 0; i < NI; i++) div[i] = 0;
    end
    tick(3);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int n;
    model_reset();
    line = 9'd100; pixel = 10'd200;
    tick(3);
    chk("rst_x", 0, o_x[0], 312);
    chk("rst_y", 0, o_y[0], 232);
    chk("rst_dx", 0, o_dx[0], 1);
    chk("rst_dy", 0, o_dy[0], 1);
    chk("rst_cnt", 0, o_cnt[0], 0);
    chk("rst_on", 0, o_on[0], 0);
    chk("rst_rgb", 0, o_rgb[0], 0);
    reset = 1'b0;
    tick(2);

    line = 9'd232; pixel = 10'd312; tick(1);
    chk("ras_on_tl", 0, o_on[0], 1);
    chk("ras_rgb_tl", 0, o_rgb[0], 3'b100);
    pixel = 10'd328; tick(1);
    chk("ras_on_right", 0, o_on[0], 0);
    chk("ras_rgb_right", 0, o_rgb[0], 3'b001);
    line = 9'd247; pixel = 10'd327; tick(1);
    chk("ras_on_br", 0, o_on[0], 1);
    line = 9'd248; tick(1);
    chk("ras_on_below", 0, o_on[0], 0);
    line = 9'd0; pixel = 10'd312; tick(1);
    chk("ras_rgb_blank", 0, o_rgb[0], 0);
    pixel = '0;

    set_run(1'b1);
    frame();
    chk("rw_x1", 2, o_x[2], 624);
    chk("cor_x", 3, o_x[3], 625);
    chk("cor_y", 3, o_y[3], 465);
    chk("cor_dx", 3, o_dx[3], 0);
    chk("cor_dy", 3, o_dy[3], 0);
    chk("cor_cnt", 3, o_cnt[3], 1);
    chk("cor_pulses", 3, pulses[3], 1);
    frame();
    chk("rw_x2", 2, o_x[2], 625);
    chk("rw_dx2", 2, o_dx[2], 0);
    chk("rw_cnt2", 2, o_cnt[2], 1);
    frame();
    chk("rw_x3", 2, o_x[2], 621);
    chk("mot_x", 0, o_x[0], 318);
    chk("mot_y", 0, o_y[0], 235);
    chk("div2_x", 1, o_x[1], 314);
    chk("div2_y", 1, o_y[1], 233);

    speed_sel = 2'd2; frame(); frame();
    speed_sel = 2'd1; frame();
    chk("spd_x", 0, o_x[0], 334);
    chk("spd_y", 0, o_y[0], 243);

    line = 9'd250;
    for (int p = 330; p < 354; p++) begin
      pixel = 10'(p);
      tick(1);
    end
    line = '0; pixel = '0;
    speed_sel = 2'd0;

    set_run(1'b0);
    frame(); frame();
    chk("frz_x", 0, o_x[0], 334);
    set_run(1'b1);

    v_sync = 1'b0;
    model_fall();
    tick(2);
    v_sync = 1'b1;
    tick(3);
    reset = 1'b1;
    model_reset();
    tick(1);
    chk("mid_rst_x", 0, o_x[0], 312);
    chk("mid_rst_y", 0, o_y[0], 232);
    reset = 1'b0;
    tick(3);
    frame();
    chk("post_rst_x", 0, o_x[0], 314);
    chk("post_rst_y", 0, o_y[0], 233);

    n = 0;
    while (mhits[4] < 256 && n < 800) begin
      frame();
      n++;
    end
    chk("sat_hits_reached", 4, (mhits[4] >= 256) ? 1 : 0, 1);
    chk("sat_cnt", 4, o_cnt[4], 255);
    chk("sat_pulses", 4, pulses[4], mhits[4]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ball_motion_ctrl.md
Name: ball_motion_ctrl

Overview:
- Frame-synchronous controller for the bouncing-ball display on the 640x480 VGA path.
- Consumes the sync generator's v_sync, line and pixel outputs.
- Steps the ball position once per N frames, only during vertical blanking, and reflects it off the screen edges.
- Drives the per-pixel ball/background colour for the DAC.

Parameters:
H_RES, 640, active pixels per line; pixel counts 1..H_RES, 0 = blank
V_RES, 480, active lines; line counts 1..V_RES, 0 = blank
BALL_SIZE, 16, ball edge length in pixels/lines
STEP_X, 2, base horizontal step per update
STEP_Y, 1, base vertical step per update
INIT_X, 312, reset left edge of ball
INIT_Y, 232, reset top edge of ball
FRAME_DIV, 1, frames per position update (>=1)
BALL_RGB, 3'b100, colour inside ball
BG_RGB, 3'b001, colour outside ball during active video

Ports:
clk  in  1  pixel clock, same clock as the sync generator
reset  in  1  asynchronous, active-high reset
v_sync  in  1  active-low vertical sync from the sync generator
line  in  9  current active line, 1..480, 0 in blanking
pixel  in  10  current active pixel, 1..640, 0 in blanking
run  in  1  1 = ball moves, 0 = ball frozen
speed_sel  in  2  step multiplier; step = base*(speed_sel+1)
ball_x  out  10  ball left edge, range 1..XMAX, XMAX = H_RES-BALL_SIZE+1
ball_y  out  9  ball top edge, range 1..YMAX, YMAX = V_RES-BALL_SIZE+1
dir_x  out  1  1 = moving right
dir_y  out  1  1 = moving down
bounce  out  1  one-clk pulse on the COMMIT cycle when any wall was hit
bounce_cnt  out  8  wall-hit count, saturates at 255
ball_on  out  1  registered: raster inside ball
rgb  out  3  registered colour; 0 when line==0 or pixel==0

Behaviour:
- Reset values: ball_x=INIT_X, ball_y=INIT_Y, dir_x=1, dir_y=1, bounce=0, bounce_cnt=0, ball_on=0, rgb=0. Reset also sets FSM=IDLE and clears the divider.
- v_sync path: 2-flop synchroniser, then falling-edge detect, giving frame_tick (1 clk). Latency from the v_sync fall to frame_tick is 3 clk.
- FSM states: IDLE, WAIT_FRAME, CALC_X, CALC_Y, COMMIT.
- IDLE: if run=1, go to WAIT_FRAME and clear the divider.
- WAIT_FRAME: if run=0, go to IDLE; this check takes priority over frame_tick.
  - On frame_tick with div==FRAME_DIV-1: clear div, latch speed_sel, go to CALC_X.
  - Otherwise on frame_tick: div++.
- CALC_X, CALC_Y, COMMIT ignore run. Each state lasts 1 clk. COMMIT returns to WAIT_FRAME.
- Outputs change only in COMMIT, at most 6 clk after the v_sync fall. Line is 0 at that point, so there is no tearing.
- CALC_X arithmetic, done in 11-bit signed: nx = ball_x ± STEP_X*(speed_sel+1).
  - If nx >= XMAX: nx = XMAX, clear dir_x, set hit.
  - If nx <= 1: nx = 1, set dir_x, set hit.
  - Landing exactly on a wall counts as a hit.
- CALC_Y: same rule with STEP_Y, YMAX and dir_y.
- COMMIT: load ball_x, ball_y, dir_x, dir_y. If hit (X or Y): bounce=1 for this clk and bounce_cnt+1, saturating.
- A corner hit (X and Y in the same update) produces one pulse and +1, not +2.
- Raster compare, 1 clk latency, every clk in every state:
  - ball_on = (line!=0) & (pixel!=0) & (pixel>=ball_x) & (pixel<ball_x+BALL_SIZE) & (line>=ball_y) & (line<ball_y+BALL_SIZE).
  - rgb = ball_on ? BALL_RGB : (line!=0 & pixel!=0 ? BG_RGB : 0).
- Reset asserted mid-update (any state): all outputs take reset values immediately; no partial commit.
- speed_sel changes outside the latch cycle have no effect until the next update.

Decomposition:
- Package ball_pkg: H_RES, V_RES, BALL_SIZE, colour constants, and the FSM state enum typedef shared with future paddle/score blocks.
- One sub-module, sync_fall_det: 2-flop synchroniser plus falling-edge pulse. Reusable for h_sync.

Test Plan:
1. Reset: assert reset mid-frame, then release -> ball_x=312, ball_y=232, dir_x=1, dir_y=1, bounce_cnt=0, ball_on=0, rgb=0.
2. Normal motion: run=1, speed_sel=0, 3 v_sync falls -> ball_x=318, ball_y=235. Each update lands within 6 clk of its v_sync fall while line==0. With FRAME_DIV=2, 3 falls give 1 update.
3. Right wall: INIT_X=620, STEP_X=4, run=1 -> ball_x goes 624, then 625 with dir_x=0, one bounce pulse and bounce_cnt=1, then 621.
4. Corner: INIT_X=623, INIT_Y=464 -> both axes clamp in the same COMMIT to (625,465); dir_x=0, dir_y=0; single bounce pulse; bounce_cnt=1. Continue until 255 hits, then one more hit -> bounce_cnt stays 255.
5. Raster: ball at (312,232).
   - line=232, pixel=312 -> ball_on=1 and rgb=3'b100 next clk.
   - pixel=328 -> ball_on=0, rgb=3'b001.
   - line=0 -> rgb=0.
6. Control: run=0 during WAIT_FRAME, v_sync falls -> position unchanged. Reset pulsed during CALC_Y -> immediate reset values, and the next COMMIT starts from INIT_X/INIT_Y.
